gcd_req_feeder: RTL and testbench

Request-side feeder that sits directly upstream of the GCD unit. It holds a buffer of up to DEPTH operand-pair vectors, loaded through a simple write port. On a start command it streams vectors 0..N-1 in order onto the GCD unit's req_msg/req_val/req_rdy handshake, then signals completion. The buffer is modelled as a 1-cycle-read-latency SRAM so the block maps onto a macro later.

---
 rtl/gcd_req_feeder_if.sv | 12 +
 rtl/gcd_req_feeder.sv | 175 +++++++++++++++++
 tb/tb_gcd_req_feeder.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/gcd_req_feeder_if.sv
// Request handshake between the vector feeder (master) and the GCD unit (slave).
// req_val/req_msg are driven by the master; req_rdy is the downstream acceptance.
interface gcd_req_feeder_if #(
    parameter int MSG_WIDTH = 32
);
    logic [MSG_WIDTH-1:0] req_msg;
    logic                 req_val;
    logic                 req_rdy;

    modport master (output req_msg, output req_val, input req_rdy);
    modport slave  (input req_msg, input req_val, output req_rdy);
endinterface

// File: rtl/gcd_req_feeder.sv
// Vector buffer + streamer feeding the GCD unit; first req_val 2 cycles after start, 1 vector/cycle sustained.
// Backpressure: req_rdy low stalls the 2-entry skid; req_val/req_msg hold until accepted.

// Generic synchronous FIFO with head visible combinationally on pop_dat.
module gcd_req_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             empty,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end
endmodule

module gcd_req_feeder #(
    parameter int DEPTH      = 128,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int MSG_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [MSG_WIDTH-1:0]  wr_data,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   num_vec,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   issued_cnt,
    gcd_req_feeder_if.master      req
);
    localparam int CW = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state;
    state_t state_nxt;

    logic [MSG_WIDTH-1:0] buf_mem [DEPTH];
    logic [MSG_WIDTH-1:0] rd_q;
    logic                 rd_vld;
    logic                 rd_en;
    logic [CW-1:0]        n_vec;
    logic [CW-1:0]        rd_ptr;
    logic [CW-1:0]        num_clamped;
    logic                 start_ok;

    logic [MSG_WIDTH-1:0] fifo_dat;
    logic                 fifo_empty;
    logic [1:0]           fifo_count;
    logic                 fifo_push;
    logic                 fifo_pop;

    logic [MSG_WIDTH-1:0] head;
    logic                 val_int;
    logic                 hs;
    logic                 last_hs;
    logic [2:0]           occ;
    logic [2:0]           occ_lim;

    assign start_ok    = (state == IDLE) && start;
    assign num_clamped = (num_vec > CW'(DEPTH)) ? CW'(DEPTH) : num_vec;

    // The SRAM output register acts as the skid's front slot: it is presented
    // directly when the FIFO is empty and is parked in the FIFO if not taken.
    assign val_int   = !fifo_empty || rd_vld;
    assign head      = fifo_empty ? rd_q : fifo_dat;
    assign hs        = val_int && req.req_rdy;
    assign fifo_push = rd_vld && !(fifo_empty && hs);
    assign fifo_pop  = hs && !fifo_empty;
    assign last_hs   = hs && ((issued_cnt + CW'(1)) == n_vec);

    // Occupancy is counted net of this cycle's pop so a full-rate stream never bubbles.
    assign occ     = {1'b0, fifo_count} + {2'b00, rd_vld};
    assign occ_lim = 3'd2 + {2'b00, hs};
    assign rd_en   = (state == RUN) && (rd_ptr < n_vec) && (occ < occ_lim);

    gcd_req_fifo #(
        .WIDTH (MSG_WIDTH),
        .DEPTH (2)
    ) u_skid (
        .clk      (clk),
        .reset    (reset),
        .push     (fifo_push),
        .push_dat (rd_q),
        .pop      (fifo_pop),
        .pop_dat  (fifo_dat),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (num_vec == '0) ? DONE : RUN;
            RUN:     if (last_hs) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy        = (state != IDLE);
        done        = (state == DONE);
        req.req_val = val_int;
        req.req_msg = val_int ? head : '0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            n_vec      <= '0;
            rd_ptr     <= '0;
            issued_cnt <= '0;
            rd_vld     <= 1'b0;
        end else begin
            rd_vld <= rd_en;
            if (start_ok) begin
                n_vec      <= num_clamped;
                rd_ptr     <= '0;
                issued_cnt <= '0;
            end else begin
                if (rd_en) rd_ptr     <= rd_ptr + CW'(1);
                if (hs)    issued_cnt <= issued_cnt + CW'(1);
            end
        end
    end

    // Buffer macro: contents survive reset; rd_ptr < n_vec <= DEPTH keeps the address in range.
    always_ff @(posedge clk) begin
        if (wr_en && (state == IDLE)) buf_mem[wr_addr] <= wr_data;
        if (rd_en) rd_q <= buf_mem[rd_ptr[ADDR_WIDTH-1:0]];
    end
endmodule

// File: tb/tb_gcd_req_feeder.sv
// Randomized self-checking bench for gcd_req_feeder against an array/queue reference model.
module tb_gcd_req_feeder;
    localparam int DEPTH = 128;
    localparam int AW    = 7;
    localparam int MW    = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [MW-1:0] wr_data = '0;
    logic          start = 1'b0;
    logic [AW:0]   num_vec = '0;
    logic          busy;
    logic          done;
    logic [AW:0]   issued_cnt;

    gcd_req_feeder_if #(.MSG_WIDTH(MW)) req_if ();

    gcd_req_feeder #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (AW),
        .MSG_WIDTH  (MW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .start      (start),
        .num_vec    (num_vec),
        .busy       (busy),
        .done       (done),
        .issued_cnt (issued_cnt),
        .req        (req_if.master)
    );

    always #5 clk = ~clk;

    logic [MW-1:0] model [DEPTH];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input int addr, input logic [MW-1:0] d);
        wr_en   = 1'b1;
        wr_addr = addr[AW-1:0];
        wr_data = d;
        tick();
        wr_en = 1'b0;
        model[addr] = d;
    endtask

    // mode: 0 rdy always, 1 pattern 1,0,0,1, 2 random, 3 stalled until cycle 6
    task automatic do_run(input int nv, input int mode, input int abort_after, input bit lockout);
        logic [MW-1:0] expq[$];
        logic [MW-1:0] held_msg;
        logic          held;
        bit            rdy;
        int nexp, hs, cyc, first_val, done_cyc, last_hs, k;
        nexp = (nv > DEPTH) ? DEPTH : nv;
        for (int i = 0; i < nexp; i++) expq.push_back(model[i]);
        hs = 0; first_val = -1; done_cyc = -1; last_hs = -1; held = 1'b0; held_msg = '0;
        req_if.req_rdy = 1'b0;
        start   = 1'b1;
        num_vec = nv[AW:0];
        tick();
        start = 1'b0;
        cyc = 1;
        while (cyc < 1000) begin
            if (held) begin
                check("hold_val", req_if.req_val, 1);
                check("hold_msg", req_if.req_msg, held_msg);
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (req_if.req_val && first_val < 0) first_val = cyc;
            k = (cyc - 1) % 4;
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (k == 0) || (k == 3);
                2:       rdy = ($urandom_range(0, 1) == 1);
                default: rdy = (cyc >= 6);
            endcase
            if (lockout && cyc == 3) begin
                start = 1'b1; num_vec = 5; wr_en = 1'b1; wr_addr = '0; wr_data = '1;
            end else begin
                start = 1'b0; wr_en = 1'b0;
            end
            req_if.req_rdy = rdy;
            held     = req_if.req_val && !rdy;
            held_msg = req_if.req_msg;
            if (req_if.req_val && rdy) begin
                if (hs < nexp) check("msg", req_if.req_msg, expq[hs]);
                else           check("extra_hs", hs, nexp);
                hs++;
                last_hs = cyc;
            end
            tick();
            cyc++;
            if (abort_after >= 0 && hs == abort_after) begin
                req_if.req_rdy = 1'b0;
                check("mid_issued", issued_cnt, abort_after);
                reset = 1'b0;
                tick();
                check("rst_busy", busy, 0);
                check("rst_done", done, 0);
                check("rst_val", req_if.req_val, 0);
                check("rst_msg", req_if.req_msg, 0);
                check("rst_issued", issued_cnt, 0);
                reset = 1'b1;
                repeat (3) begin
                    tick();
                    check("post_rst_val", req_if.req_val, 0);
                end
                return;
            end
        end
        start = 1'b0;
        wr_en = 1'b0;
        if (done_cyc < 0) begin
            check("timeout", 0, 1);
        end else begin
            check("hs_count", hs, nexp);
            check("done_val_low", req_if.req_val, 0);
            check("done_busy", busy, 1);
            if (nexp == 0) begin
                check("zero_done_cyc", done_cyc, 1);
                check("zero_no_val", first_val, -1);
            end else begin
                check("first_val_cyc", first_val, 2);
                check("done_after_last", done_cyc, last_hs + 1);
            end
            if (mode == 0 && nexp > 0) check("stream_cycles", done_cyc, nexp + 2);
            tick();
            check("done_pulse", done, 0);
            check("busy_after", busy, 0);
            check("issued_cnt", issued_cnt, nexp);
            check("val_after", req_if.req_val, 0);
        end
        req_if.req_rdy = 1'b0;
    endtask

    initial begin
        req_if.req_rdy = 1'b0;
        reset = 1'b0;
        tick();
        tick();
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_val", req_if.req_val, 0);
        check("reset_msg", req_if.req_msg, 0);
        check("reset_issued", issued_cnt, 0);
        reset = 1'b1;
        tick();

        write_word(0, 32'h00030006);
        write_word(1, 32'h0005000A);
        write_word(2, 32'h0007000E);
        write_word(3, 32'h000C0012);
        do_run(4, 0, -1, 1'b0);
        do_run(4, 1, -1, 1'b0);
        do_run(0, 0, -1, 1'b0);

        for (int i = 0; i < DEPTH; i++) write_word(i, 32'hC0DE0000 | i);
        do_run(200, 0, -1, 1'b0);

        do_run(8, 0, 3, 1'b0);
        do_run(2, 0, -1, 1'b0);

        do_run(8, 3, -1, 1'b1);
        do_run(1, 0, -1, 1'b0);

        repeat (6) begin
            int nw;
            nw = $urandom_range(1, 10);
            for (int j = 0; j < nw; j++) write_word($urandom_range(0, DEPTH - 1), $urandom);
            do_run($urandom_range(0, 140), 2, -1, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
